// File: rtl/sram_ctrl.sv
// Multi-cycle controller bridging a 32-bit MEM-stage access onto a 16-bit asynchronous SRAM.
// Each access moves two half-words (low, then high) and freezes the pipeline until DONE.
module sram_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

    // Cycles spent in WAIT; zero when ACCESS_CYCLES is at its minimum of 4.
    localparam logic [3:0] WAIT_CYCLES = 4'(ACCESS_CYCLES - 4);

    state_t      state_q, state_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] offset;

    assign offset    = address - BASE_ADDR;
    assign read_data = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        cnt_d       = '0;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state_q)
            IDLE: begin
                ready = !(rd_en || wr_en);
                if (rd_en || wr_en) begin
                    state_d = LOW;
                    word_d  = offset[18:2];
                    wdata_d = write_data;
                    // A simultaneous read and write request is serviced as a read.
                    is_wr_d = wr_en && !rd_en;
                end
            end
            LOW: begin
                sram_addr = {word_q, 1'b0};
                if (is_wr_q) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    rdata_d[15:0] = sram_dq_in;
                end
                state_d = HIGH;
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (is_wr_q) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    rdata_d[31:16] = sram_dq_in;
                end
                state_d = (WAIT_CYCLES == 4'd0) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES - 4'd1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM attached to the half-word bus.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    // Asynchronous read, write committed on the rising edge while strobed.
    assign sram_dq_in = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full access; exp_word is the hand-computed SRAM word index.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [16:0] exp_word,
                              input logic [31:0] exp_rd);
        logic is_wr;
        is_wr = wr && !rd;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        @(negedge clk);
        check("c0_ready", {31'd0, ready}, 32'd0);
        next_cycle();
        // Inputs scrambled to prove the access uses the latched copies.
        rd_en = 1'b0; wr_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
        @(negedge clk);
        check("c1_addr", {14'd0, sram_addr}, {14'd0, exp_word, 1'b0});
        check("c1_we_n", {31'd0, sram_we_n}, {31'd0, !is_wr});
        check("c1_oe", {31'd0, sram_dq_oe}, {31'd0, is_wr});
        if (is_wr) check("c1_dq", {16'd0, sram_dq_out}, {16'd0, d[15:0]});
        check("c1_ready", {31'd0, ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("c2_addr", {14'd0, sram_addr}, {14'd0, exp_word, 1'b1});
        check("c2_we_n", {31'd0, sram_we_n}, {31'd0, !is_wr});
        if (is_wr) check("c2_dq", {16'd0, sram_dq_out}, {16'd0, d[31:16]});
        check("c2_ready", {31'd0, ready}, 32'd0);
        for (int i = 3; i <= 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("wait_ready", {31'd0, ready}, 32'd0);
            check("wait_we_n", {31'd0, sram_we_n}, 32'd1);
            check("wait_addr", {14'd0, sram_addr}, 32'd0);
        end
        next_cycle();
        @(negedge clk);
        check("c5_ready", {31'd0, ready}, 32'd1);
        check("c5_rdata", read_data, exp_rd);
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        #2;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, ready}, 32'd1);
            check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
            check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
            next_cycle();
        end

        run_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 17'd0, 32'h0000_0000);
        run_access(1'b1, 1'b0, 32'd1024, 32'h0000_0000, 17'd0, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 17'd1, 32'hDEAD_BEEF);
        run_access(1'b1, 1'b0, 32'd1028, 32'h0000_0000, 17'd1, 32'h1234_5678);
        run_access(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, 17'd0, 32'hDEAD_BEEF);
        check("mem0_kept", {16'd0, mem[0]}, 32'h0000_BEEF);
        check("mem1_kept", {16'd0, mem[1]}, 32'h0000_DEAD);

        // Write aborted by reset while in HIGH.
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hAAAA_5555;
        next_cycle();
        wr_en = 1'b0;
        next_cycle();
        @(negedge clk);
        check("abort_pre_we_n", {31'd0, sram_we_n}, 32'd0);
        check("abort_pre_addr", {14'd0, sram_addr}, 32'd5);
        #1 rst = 1'b1;
        #1;
        check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("abort_addr", {14'd0, sram_addr}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_rdata", read_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("post_ready", {31'd0, ready}, 32'd1);
        check("post_rdata", read_data, 32'd0);
        check("post_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mem5_untouched", {16'd0, mem[5]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024: byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter ACCESS_CYCLES, default 6: cycles from request to ready, inclusive; legal range 4..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rd_en  input  1  load request from MEM stage (memRead).
REQ-006 SHALL have port wr_en  input  1  store request from MEM stage (memWrite).
REQ-007 SHALL have port address  input  32  byte address of the access.
REQ-008 SHALL have port write_data  input  32  store data.
REQ-009 SHALL have port read_data  output  32  load data to WB stage.
REQ-010 SHALL have port ready  output  1  access complete; the pipeline freezes while this is 0.
REQ-011 SHALL have port sram_addr  output  18  SRAM half-word address.
REQ-012 SHALL have port sram_dq_out  output  16  SRAM write data.
REQ-013 SHALL have port sram_dq_oe  output  1  drive enable for sram_dq_out.
REQ-014 SHALL have port sram_dq_in  input  16  SRAM read data, asynchronous from SRAM.
REQ-015 SHALL have port sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 SHALL implement the states IDLE, LOW, HIGH, WAIT and DONE.
REQ-017 SHALL, in IDLE, move to LOW on the next edge if rd_en|wr_en, else stay in IDLE.
REQ-018 SHALL drive ready combinationally as 1 in IDLE with no request, 1 in DONE, and 0 otherwise, so the request cycle already sees ready=0.
REQ-019 SHALL go LOW->HIGH->WAIT, hold WAIT for ACCESS_CYCLES-4 cycles, then go DONE->IDLE.
REQ-020 SHALL give a latency where ready is 0 for ACCESS_CYCLES-1 cycles starting at the request cycle and 1 in cycle ACCESS_CYCLES-1 (DONE).
REQ-021 SHALL form addressing as word = (address - BASE_ADDR) >> 2, truncated to 17 bits, with sram_addr = {word, 1'b0} in LOW and {word, 1'b1} in HIGH; no range check, wraps modulo 2^17 words.
REQ-022 SHALL latch address and write_data at the IDLE->LOW edge; later changes to the inputs during an access SHALL be ignored.
REQ-023 SHALL perform reads as: capture sram_dq_in into read_data[15:0] at the LOW->HIGH edge and into read_data[31:16] at the HIGH->WAIT edge.
REQ-024 SHALL hold read_data until the next read overwrites it; writes SHALL not alter read_data.
REQ-025 SHALL perform writes as: in LOW, sram_dq_out = write_data[15:0], sram_dq_oe=1, sram_we_n=0; in HIGH, sram_dq_out = write_data[31:16], sram_dq_oe=1, sram_we_n=0.
REQ-026 SHALL otherwise hold sram_we_n=1 and sram_dq_oe=0.
REQ-027 SHALL treat rd_en and wr_en asserted together as a read, with no SRAM write.
REQ-028 SHALL, in DONE, on the next edge go to IDLE regardless of request; a request still present in IDLE starts a new access.
REQ-029 SHALL default sram_addr to 0 in IDLE, WAIT and DONE.

Reset
REQ-030 SHALL, on rst=1, immediately set state IDLE, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0 and the wait counter to 0.
REQ-031 SHALL make ready=1 during reset and after release while no request is present.
REQ-032 SHALL abort an access on reset mid-access, with no further SRAM strobes; a write aborted in LOW or HIGH may leave partial SRAM contents.

Verification
REQ-033 SHALL be verified for: idle, rd_en=wr_en=0 -> ready=1 every cycle, sram_we_n=1, sram_dq_oe=0.
REQ-034 SHALL be verified for: wr_en, address=1024, write_data=32'hDEADBEEF -> sram_addr 0 with data BEEF and we_n=0, then sram_addr 1 with data DEAD and we_n=0; ready=0 for cycles 0-4 and ready=1 in cycle 5.
REQ-035 SHALL be verified for: rd_en, address=1024 after the previous write, with an SRAM model attached -> read_data=32'hDEADBEEF while ready=1 in cycle 5.
REQ-036 SHALL be verified for: address=1028 write of 32'h12345678 -> sram_addr 2 then 3; a back-to-back read of 1028 started in the cycle after DONE returns 32'h12345678.
REQ-037 SHALL be verified for: rd_en=wr_en=1 -> sram_we_n stays 1 for the whole access; read_data is updated.
REQ-038 SHALL be verified for: rst asserted in the HIGH state of a write -> sram_we_n=1 and state IDLE in the same cycle; with no request after release, ready=1 and read_data=0.
